// File: rtl/clk_div_n.sv
// clk_div_n: runtime-programmable integer clock divider with boundary-applied loads; CLK_DIV_ODD_DUTY50_EN gives 50% duty for odd N
module clk_div_n #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(3)
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] div_in_i,
  input  logic             div_load_i,
  output logic             clk_out_o,
  output logic             tick_o,
  output logic [WIDTH-1:0] div_cur_o,
  output logic             div_err_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d, div_q, div_d, pend_q, pend_d, half;
  logic             clk_q, clk_d, tick_q, tick_d, err_q, err_d, pv_q, pv_d, wrap;
  always_comb begin
    half   = div_q >> 1;
    wrap   = cnt_q == div_q - WIDTH'(1);
    cnt_d  = cnt_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    div_d  = div_q;
    pend_d = pend_q;
    pv_d   = pv_q;
    err_d  = 1'b0;
    if (en_i) begin
      cnt_d  = wrap ? '0 : cnt_q + WIDTH'(1);
      clk_d  = (cnt_q == '0) ? 1'b1 : (cnt_q == half) ? 1'b0 : clk_q;
      tick_d = cnt_q == '0;
      if (wrap && pv_q) begin
        div_d = pend_q;
        pv_d  = 1'b0;
      end
    end
    // A load on the apply edge lands in pend only, so it overrides the clear above
    if (div_load_i) begin
      if (div_in_i > WIDTH'(1)) begin
        pend_d = div_in_i;
        pv_d   = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
      err_q  <= 1'b0;
      div_q  <= DEFAULT_DIV;
      pend_q <= '0;
      pv_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      err_q  <= err_d;
      div_q  <= div_d;
      pend_q <= pend_d;
      pv_q   <= pv_d;
    end
  end
`ifdef CLK_DIV_ODD_DUTY50_EN
  logic neg_q;
  always_ff @(negedge clk_i) begin
    neg_q <= reset_ni ? clk_q : 1'b0;
  end
  assign clk_out_o = clk_q | (div_q[0] & neg_q);
`else
  assign clk_out_o = clk_q;
`endif
  assign tick_o    = tick_q;
  assign div_cur_o = div_q;
  assign div_err_o = err_q;
endmodule

// File: tb/tb_clk_div_n.sv
// tb_clk_div_n: directed plus randomized stimulus checked against a period-queue reference model
module tb_clk_div_n;
  logic       clk = 1'b1;
  logic       reset_n = 1'b0, en = 1'b0, div_load = 1'b0;
  logic [7:0] div_in = '0;
  logic       clk_out, tick, div_err;
  logic [7:0] div_cur;
  int         checks = 0, errors = 0;
  int         m_cur = 3, m_pend = 0;
  bit         m_pv = 0;
  logic       m_clk = 1'b0, m_prev = 1'b0, exp_tick, exp_err, exp_out;
  logic [1:0] q[$];
  clk_div_n #(.WIDTH(8), .DEFAULT_DIV(8'd3)) dut (
    .clk_i(clk), .reset_ni(reset_n), .en_i(en), .div_in_i(div_in), .div_load_i(div_load),
    .clk_out_o(clk_out), .tick_o(tick), .div_cur_o(div_cur), .div_err_o(div_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s t=%0t got %0h expected %0h", name, $time, got, exp);
    end
  endtask
  // Each period is a queue of {first, level} entries consumed one per enabled edge
  task automatic step(input logic e, input logic ld, input logic [7:0] d, input logic r);
    en = e; div_load = ld; div_in = d; reset_n = r;
    @(posedge clk);
    m_prev = m_clk; exp_tick = 1'b0; exp_err = 1'b0;
    if (!r) begin
      m_clk = 1'b0; m_cur = 3; m_pv = 0; q.delete();
    end else begin
      if (e) begin
        if (q.size() == 0)
          for (int i = 0; i < m_cur; i++) q.push_back({i == 0, i < m_cur / 2});
        {exp_tick, m_clk} = q.pop_front();
        if (q.size() == 0 && m_pv) begin m_cur = m_pend; m_pv = 0; end
      end
      if (ld) begin
        if (d >= 2) begin m_pend = d; m_pv = 1; end
        else exp_err = 1'b1;
      end
    end
`ifdef CLK_DIV_ODD_DUTY50_EN
    exp_out = m_clk | ((m_cur % 2 == 1) & m_prev);
`else
    exp_out = m_clk;
`endif
    #1;
    chk("clk_out", 32'(clk_out), 32'(exp_out));
    chk("tick", 32'(tick), 32'(exp_tick));
    chk("div_cur", 32'(div_cur), 32'(m_cur));
    chk("div_err", 32'(div_err), 32'(exp_err));
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'd0, 1'b1);
  endtask
  initial begin
    step(1'b1, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b0, 8'd0, 1'b0);
    run(7);
    step(1'b1, 1'b1, 8'd4, 1'b1);
    run(12);
    step(1'b1, 1'b1, 8'd1, 1'b1);
    run(1);
    step(1'b1, 1'b1, 8'd0, 1'b1);
    run(5);
    for (int i = 0; i < 10 && m_clk !== 1'b1; i++) run(1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'd0, 1'b1);
    run(6);
    step(1'b1, 1'b1, 8'd5, 1'b1);
    step(1'b1, 1'b1, 8'd6, 1'b1);
    step(1'b1, 1'b1, 8'd7, 1'b1);
    step(1'b1, 1'b0, 8'd0, 1'b0);
    run(9);
    step(1'b1, 1'b1, 8'd2, 1'b1);
    run(8);
    step(1'b1, 1'b1, 8'd255, 1'b1);
    run(700);
    step(1'b0, 1'b1, 8'd3, 1'b1);
    step(1'b0, 1'b0, 8'd0, 1'b1);
    run(300);
    for (int i = 0; i < 2000; i++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 1)) : 8'($urandom_range(2, 12));
      step($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0, d, $urandom_range(0, 199) != 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
